// File: rtl/arm7_mem_arbiter_if.sv
// Shared ARM7 memory port bundle: two requesting masters plus the memory side.
// The arbiter takes the slave view; the masters/memory model take the master view.
interface arm7_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          nMREQ0;
    logic          nMREQ1;
    logic          nRW0;
    logic          nRW1;
    logic [1:0]    MAS0;
    logic [1:0]    MAS1;
    logic [AW-1:0] A0;
    logic [AW-1:0] A1;
    logic [DW-1:0] DOUT0;
    logic [DW-1:0] DOUT1;
    logic          LOCK0;
    logic          LOCK1;
    logic          nWAIT0;
    logic          nWAIT1;
    logic [DW-1:0] DIN;
    logic          nMREQ;
    logic          nRW;
    logic [1:0]    MAS;
    logic [AW-1:0] A;
    logic [DW-1:0] MDOUT;
    logic [DW-1:0] MDIN;
    logic          nWAIT;
    logic [1:0]    GNT;

    modport slave (
        input  nMREQ0, nMREQ1, nRW0, nRW1, MAS0, MAS1,
        input  A0, A1, DOUT0, DOUT1, LOCK0, LOCK1,
        output nWAIT0, nWAIT1, DIN,
        output nMREQ, nRW, MAS, A, MDOUT,
        input  MDIN, nWAIT,
        output GNT
    );

    modport master (
        output nMREQ0, nMREQ1, nRW0, nRW1, MAS0, MAS1,
        output A0, A1, DOUT0, DOUT1, LOCK0, LOCK1,
        input  nWAIT0, nWAIT1, DIN,
        input  nMREQ, nRW, MAS, A, MDOUT,
        output MDIN, nWAIT,
        input  GNT
    );
endinterface

// File: rtl/arm7_mem_arbiter.sv
// Round-robin arbiter sharing one ARM7 memory port between two masters,
// with a per-grant burst limit and a lock that keeps swap sequences atomic.
module arm7_mem_arbiter #(
    parameter int BURST_MAX = 4
) (
    input  logic                sysclk,
    input  logic                RESET,
    arm7_mem_arbiter_if.slave   bus
);
    localparam int CW = $clog2(BURST_MAX + 1);
    localparam logic [CW:0]   LIMIT = (CW + 1)'(BURST_MAX);
    localparam logic [CW-1:0] CMAX  = CW'(BURST_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_t;

    state_t        r_state;
    state_t        w_next;
    state_t        w_other;
    logic          r_last;
    logic          w_last_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW:0]   w_sum;
    logic          w_g0;
    logic          w_g1;
    logic          w_req0;
    logic          w_req1;
    logic          w_own_req;
    logic          w_oth_req;
    logic          w_own_lock;
    logic          w_cmp;
    logic          w_bnd;
    logic          w_limit;

    assign w_g0       = (r_state == G0);
    assign w_g1       = (r_state == G1);
    assign w_req0     = ~bus.nMREQ0;
    assign w_req1     = ~bus.nMREQ1;
    assign w_own_req  = (w_g0 & w_req0) | (w_g1 & w_req1);
    assign w_oth_req  = (w_g0 & w_req1) | (w_g1 & w_req0);
    assign w_own_lock = (w_g0 & bus.LOCK0) | (w_g1 & bus.LOCK1);
    assign w_cmp      = w_own_req & bus.nWAIT;
    assign w_bnd      = (w_g0 | w_g1) & (w_cmp | ~w_own_req);
    assign w_sum      = {1'b0, r_cnt} + {{CW{1'b0}}, w_cmp};
    assign w_limit    = (w_sum >= LIMIT);
    assign w_other    = w_g0 ? G1 : G0;

    // Next grant: hand off only at transfer boundaries, never mid-stall.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_req0 && w_req1) begin
                    w_next = r_last ? G0 : G1;
                end else if (w_req0) begin
                    w_next = G0;
                end else if (w_req1) begin
                    w_next = G1;
                end
            end
            G0, G1: begin
                if (w_bnd) begin
                    if (w_own_lock && w_own_req) begin
                        w_next = r_state;
                    end else if (w_oth_req && (!w_own_req || w_limit)) begin
                        w_next = w_other;
                    end else if (w_own_req) begin
                        w_next = r_state;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Burst counter and round-robin history follow the grant decision.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_last_nxt = r_last;
        if (w_next != r_state) begin
            w_cnt_nxt = '0;
            if (w_next == G0) begin
                w_last_nxt = 1'b0;
            end else if (w_next == G1) begin
                w_last_nxt = 1'b1;
            end
        end else if (w_cmp && (r_cnt < CMAX)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // State registers; reset abandons any in-flight transfer.
    always_ff @(posedge sysclk) begin
        if (RESET) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Memory-side mux and wait routing, driven from the registered grant.
    always_comb begin
        bus.nMREQ  = 1'b1;
        bus.nRW    = 1'b0;
        bus.MAS    = 2'b00;
        bus.A      = '0;
        bus.MDOUT  = '0;
        if (w_g0) begin
            bus.nMREQ = bus.nMREQ0;
            bus.nRW   = bus.nRW0;
            bus.MAS   = bus.MAS0;
            bus.A     = bus.A0;
            bus.MDOUT = bus.DOUT0;
        end else if (w_g1) begin
            bus.nMREQ = bus.nMREQ1;
            bus.nRW   = bus.nRW1;
            bus.MAS   = bus.MAS1;
            bus.A     = bus.A1;
            bus.MDOUT = bus.DOUT1;
        end
    end

    assign bus.nWAIT0 = w_g0 & bus.nWAIT;
    assign bus.nWAIT1 = w_g1 & bus.nWAIT;
    assign bus.DIN    = bus.MDIN;
    assign bus.GNT    = {w_g1, w_g0};

endmodule
